// File: rtl/alu_mult_sequencer_if.sv
// Handshake and shared-ALU bus between the multiply sequencer and EX.
// master: EX side (owns the ALU); slave: the sequencer.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       alu_signal;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    modport master (
        output start, dataA, dataB, alu_result, alu_cout,
        input  busy, done, hi, lo, alu_signal, alu_a, alu_b
    );

    modport slave (
        input  start, dataA, dataB, alu_result, alu_cout,
        output busy, done, hi, lo, alu_signal, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle multiplier stepping the shared ALU once per cycle.
// MULT_SIGNED_EN selects radix-2 Booth; default is unsigned shift-add.
module alu_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    alu_mult_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;

    logic use_m;
    logic sub;
    logic shin;

`ifdef MULT_SIGNED_EN
    logic             q;
    logic [WIDTH-1:0] b_eff;
    logic             ovf;

    assign use_m = (state == CALC) && (lo_r[0] ^ q);
    assign sub   = (state == CALC) && lo_r[0] && !q;
    assign b_eff = sub ? ~bus.alu_b : bus.alu_b;
    // Arithmetic shift must use the true sign, not the overflowed one.
    assign ovf   = (bus.alu_a[WIDTH-1] == b_eff[WIDTH-1])
                && (bus.alu_result[WIDTH-1] != bus.alu_a[WIDTH-1]);
    assign shin  = bus.alu_result[WIDTH-1] ^ ovf;
`else
    assign use_m = (state == CALC) && lo_r[0];
    assign sub   = 1'b0;
    assign shin  = bus.alu_cout;
`endif

    assign bus.alu_signal = sub ? OP_SUB : OP_ADD;
    assign bus.alu_b      = use_m ? m : '0;
    assign bus.alu_a      = hi_r;
    assign bus.hi         = hi_r;
    assign bus.lo         = lo_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            m      <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef MULT_SIGNED_EN
            q      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m      <= bus.dataA;
                        hi_r   <= '0;
                        lo_r   <= bus.dataB;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
`ifdef MULT_SIGNED_EN
                        q      <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    hi_r <= {shin, bus.alu_result[WIDTH-1:1]};
                    lo_r <= {bus.alu_result[0], lo_r[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
`ifdef MULT_SIGNED_EN
                    q    <= lo_r[0];
`endif
                    if (cnt == CW'(WIDTH - 1)) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
